// File: rtl/sdf_pkg.sv
// Shared types and arithmetic helpers for the radix-2 SDF butterfly stage.
// Widths above SDF_MAX_W are not supported by the helper arithmetic.
package sdf_pkg;

  localparam int SDF_MAX_W  = 32;
  localparam int SDF_DATA_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    BFLY = 1'b1
  } phase_e;

  typedef struct packed {
    logic signed [SDF_DATA_W-1:0] re;
    logic signed [SDF_DATA_W-1:0] im;
  } cplx_t;

  // v is a (w+1)-bit result sign-extended to SDF_MAX_W+1 bits; caller truncates to w bits.
  function automatic logic signed [SDF_MAX_W-1:0] scale_sat(
    input logic signed [SDF_MAX_W:0] v,
    input int                        w,
    input logic                      scale_en
  );
    logic signed [SDF_MAX_W:0] hi;
    logic signed [SDF_MAX_W:0] lo;
    logic signed [SDF_MAX_W:0] r;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    if (scale_en)     r = v >>> 1;
    else if (v > hi)  r = hi;
    else if (v < lo)  r = lo;
    else              r = v;
    return SDF_MAX_W'(r);
  endfunction

endpackage

// File: rtl/sdf_r2_butterfly.sv
// Combinational radix-2 butterfly: a+b and a-b per component, with
// floor-halving (SCALE=1) or saturation to DATA_W (SCALE=0).
module sdf_r2_butterfly
  import sdf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SCALE  = 1
) (
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic signed [DATA_W-1:0] sum_re,
  output logic signed [DATA_W-1:0] sum_im,
  output logic signed [DATA_W-1:0] diff_re,
  output logic signed [DATA_W-1:0] diff_im
);

  localparam int   EW       = SDF_MAX_W + 1;
  localparam logic SCALE_EN = (SCALE != 0);

  logic signed [SDF_MAX_W:0] ar;
  logic signed [SDF_MAX_W:0] ai;
  logic signed [SDF_MAX_W:0] br;
  logic signed [SDF_MAX_W:0] bi;

  always_comb begin
    ar = EW'(a_re);
    ai = EW'(a_im);
    br = EW'(b_re);
    bi = EW'(b_im);
    sum_re  = DATA_W'(scale_sat(ar + br, DATA_W, SCALE_EN));
    sum_im  = DATA_W'(scale_sat(ai + bi, DATA_W, SCALE_EN));
    diff_re = DATA_W'(scale_sat(ar - br, DATA_W, SCALE_EN));
    diff_im = DATA_W'(scale_sat(ai - bi, DATA_W, SCALE_EN));
  end

endmodule

// File: rtl/sdf_r2_bfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage; the delay line lives in
// an external 1W1R sync-read memory driven through the mem_* ports.
module sdf_r2_bfly_stage
  import sdf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DELAY  = 512,
  parameter int ADDR_W = 9,
  parameter int SCALE  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_real,
  input  logic [DATA_W-1:0]     in_imag,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_real,
  output logic [DATA_W-1:0]     out_imag,
  output logic                  out_last,
  output logic                  frame_err,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic                  mem_wen,
  output logic [2*DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]     mem_raddr,
  output logic                  mem_ren,
  input  logic [2*DATA_W-1:0]   mem_rdata
);

  localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(DELAY - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  phase_e            phase_q, phase_d;
  logic              primed_q, primed_d;
  logic              frame_err_q, frame_err_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_re_q, out_re_d;
  logic [DATA_W-1:0] out_im_q, out_im_d;

  logic              cnt_last;
  logic [DATA_W-1:0] rd_re, rd_im;
  logic [DATA_W-1:0] sum_re, sum_im, diff_re, diff_im;

  assign rd_re = mem_rdata[2*DATA_W-1:DATA_W];
  assign rd_im = mem_rdata[DATA_W-1:0];

  sdf_r2_butterfly #(
    .DATA_W (DATA_W),
    .SCALE  (SCALE)
  ) u_bfly (
    .a_re    (rd_re),
    .a_im    (rd_im),
    .b_re    (in_real),
    .b_im    (in_imag),
    .sum_re  (sum_re),
    .sum_im  (sum_im),
    .diff_re (diff_re),
    .diff_im (diff_im)
  );

  always_comb begin
    cnt_last    = (cnt_q == CNT_MAX);
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    primed_d    = primed_q;
    frame_err_d = frame_err_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    mem_wen     = 1'b0;
    mem_wdata   = '0;

    if (in_valid) begin
      cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
      mem_wen = 1'b1;
      if (cnt_last) begin
        phase_d = (phase_q == FILL) ? BFLY : FILL;
        if (phase_q == BFLY) primed_d = 1'b1;
      end
      if (in_last && !(phase_q == BFLY && cnt_last)) frame_err_d = 1'b1;

      if (phase_q == FILL) begin
        mem_wdata = {in_real, in_imag};
        // Previous frame's differences drain out as the new frame fills.
        if (primed_q) begin
          out_valid_d = 1'b1;
          out_last_d  = cnt_last;
          out_re_d    = rd_re;
          out_im_d    = rd_im;
        end
      end else begin
        mem_wdata   = {diff_re, diff_im};
        out_valid_d = 1'b1;
        out_re_d    = sum_re;
        out_im_d    = sum_im;
      end
    end

    // Read one ahead so mem_rdata lines up with mem[cnt] on the next cycle.
    mem_raddr = !reset ? '0 : cnt_d;
    mem_waddr = cnt_q;
    mem_ren   = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q       <= '0;
      phase_q     <= FILL;
      primed_q    <= 1'b0;
      frame_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      primed_q    <= primed_d;
      frame_err_q <= frame_err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_real  = out_re_q;
  assign out_imag  = out_im_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sdf_r2_bfly_stage.sv
// Bench for sdf_r2_bfly_stage: three configurations share one input stream and
// are checked against a frame-index reference model plus literal sequences.
module tb_sdf_r2_bfly_stage;
  import sdf_pkg::*;

  localparam int NI = 3;
  localparam logic [NI-1:0][7:0] DLV = {8'd2, 8'd4, 8'd4};
  localparam logic [NI-1:0][7:0] SCV = {8'd1, 8'd0, 8'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_last;
  logic [15:0] in_re, in_im;

  logic [NI-1:0] ov, ol, fe, we, ren;
  logic [15:0]   ore [NI];
  logic [15:0]   oim [NI];
  logic [8:0]    wa  [NI];
  logic [8:0]    ra  [NI];
  logic [31:0]   wd  [NI];
  logic [31:0]   rd  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [31:0] mem [512];
    logic [31:0] q;
    sdf_r2_bfly_stage #(
      .DATA_W (16),
      .DELAY  (int'(DLV[g])),
      .ADDR_W (9),
      .SCALE  (int'(SCV[g]))
    ) u_dut (
      .clock     (clk),
      .reset     (rst_n),
      .in_valid  (in_valid),
      .in_real   (in_re),
      .in_imag   (in_im),
      .in_last   (in_last),
      .out_valid (ov[g]),
      .out_real  (ore[g]),
      .out_imag  (oim[g]),
      .out_last  (ol[g]),
      .frame_err (fe[g]),
      .mem_waddr (wa[g]),
      .mem_wen   (we[g]),
      .mem_wdata (wd[g]),
      .mem_raddr (ra[g]),
      .mem_ren   (ren[g]),
      .mem_rdata (rd[g])
    );
    always @(posedge clk) begin
      if (we[g])  mem[wa[g]] <= wd[g];
      if (ren[g]) q <= mem[ra[g]];
    end
    assign rd[g] = q;
  end

  int compared = 0;
  int mismatched = 0;

  int hist_re[$];
  int hist_im[$];
  int exp_re [NI];
  int exp_im [NI];
  bit exp_ov [NI];
  bit exp_ol [NI];
  bit exp_fe [NI];
  int n_out_model [NI];
  int n_out_dut [NI];
  int q0[$];
  int l0[$];
  int q1[$];

  int basic_exp [12] = '{3, 4, 5, 6, 'hFFFE, 'hFFFE, 'hFFFE, 'hFFFE, 0, 0, 0, 0};
  int sat_exp   [16] = '{'h7FFF, 'h7FFF, 'h7FFF, 'h7FFF, 0, 0, 0, 0,
                         'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'h8000, 'h8000, 'h8000, 'h8000};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s inst%0d: observed %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  function automatic int op(input int v, input int sc);
    int r;
    if (sc != 0) return (v >>> 1) & 32'hFFFF;
    r = v;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r & 32'hFFFF;
  endfunction

  // Sample n (since reset) sits at position p of frame f; the first half of a
  // frame is buffered, the second half pairs with it. Differences of frame f
  // come out during the first half of frame f+1.
  task automatic model_apply(input bit v, input logic [15:0] r, input logic [15:0] i, input bit last);
    int n, d, p, f, sc;
    for (int k = 0; k < NI; k++) begin
      exp_ov[k] = 1'b0;
      exp_ol[k] = 1'b0;
    end
    if (!v) return;
    n = hist_re.size();
    hist_re.push_back(int'($signed(r)));
    hist_im.push_back(int'($signed(i)));
    for (int k = 0; k < NI; k++) begin
      d  = int'(DLV[k]);
      sc = int'(SCV[k]);
      p  = n % (2 * d);
      f  = n / (2 * d);
      if (last && p != 2 * d - 1) exp_fe[k] = 1'b1;
      if (p < d) begin
        if (f > 0) begin
          exp_ov[k] = 1'b1;
          exp_ol[k] = (p == d - 1);
          exp_re[k] = op(hist_re[n - 2 * d] - hist_re[n - d], sc);
          exp_im[k] = op(hist_im[n - 2 * d] - hist_im[n - d], sc);
        end
      end else begin
        exp_ov[k] = 1'b1;
        exp_re[k] = op(hist_re[n - d] + hist_re[n], sc);
        exp_im[k] = op(hist_im[n - d] + hist_im[n], sc);
      end
      if (exp_ov[k]) n_out_model[k]++;
    end
  endtask

  task automatic step(input bit v, input logic [15:0] r, input logic [15:0] i, input bit last);
    in_valid = v;
    in_re    = r;
    in_im    = i;
    in_last  = last;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("mem_ren", k, 32'(ren[k]), 32'd1);
      chk("mem_wen", k, 32'(we[k]), 32'(v));
      if (we[k]) chk("raddr_ne_waddr", k, 32'(ra[k] != wa[k]), 32'd1);
    end
    @(posedge clk);
    #1;
    model_apply(v, r, i, last);
    for (int k = 0; k < NI; k++) begin
      if (ov[k]) n_out_dut[k]++;
      chk("out_valid", k, 32'(ov[k]), 32'(exp_ov[k]));
      chk("out_real",  k, 32'(ore[k]), 32'(exp_re[k]));
      chk("out_imag",  k, 32'(oim[k]), 32'(exp_im[k]));
      chk("out_last",  k, 32'(ol[k]), 32'(exp_ol[k]));
      chk("frame_err", k, 32'(fe[k]), 32'(exp_fe[k]));
    end
    if (ov[0]) begin
      q0.push_back(int'(ore[0]));
      l0.push_back(int'(ol[0]));
    end
    if (ov[1]) q1.push_back(int'(ore[1]));
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] i, input bit last, input int gap);
    while (gap > 0 && int'($urandom_range(99)) < gap)
      step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    step(1'b1, r, i, last);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk("ren_in_reset", k, 32'(ren[k]), 32'd1);
    @(posedge clk);
    #1;
    hist_re.delete();
    hist_im.delete();
    for (int k = 0; k < NI; k++) begin
      exp_ov[k] = 1'b0;
      exp_ol[k] = 1'b0;
      exp_re[k] = 0;
      exp_im[k] = 0;
      exp_fe[k] = 1'b0;
      chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_out_last",  k, 32'(ol[k]), 32'd0);
      chk("rst_out_real",  k, 32'(ore[k]), 32'd0);
      chk("rst_out_imag",  k, 32'(oim[k]), 32'd0);
      chk("rst_frame_err", k, 32'(fe[k]), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_basic(input int gap);
    int ones;
    q0.delete();
    l0.delete();
    for (int j = 1; j <= 8; j++) send(16'(j), 16'd0, j == 8, gap);
    for (int j = 0; j < 8; j++) send(16'd0, 16'd0, j == 7, gap);
    chk("basic_count", 0, 32'(q0.size()), 32'd12);
    ones = 0;
    for (int j = 0; j < 12; j++) begin
      chk("basic_seq", 0, (j < q0.size()) ? 32'(q0[j]) : 32'hDEAD, 32'(basic_exp[j]));
      if (j < l0.size()) ones += l0[j];
    end
    chk("basic_last_pos", 0, (l0.size() > 7) ? 32'(l0[7]) : 32'hDEAD, 32'd1);
    chk("basic_last_cnt", 0, 32'(ones), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_re    = '0;
    in_im    = '0;
    for (int k = 0; k < NI; k++) begin
      n_out_model[k] = 0;
      n_out_dut[k]   = 0;
    end

    do_reset();
    run_basic(0);
    do_reset();
    run_basic(30);

    // Random full-range data over several frames with gaps.
    do_reset();
    for (int j = 0; j < 48; j++) send(16'($urandom), 16'($urandom), (j % 8) == 7, 30);

    // Saturation corners with the unscaled instance.
    do_reset();
    q1.delete();
    for (int j = 0; j < 20; j++) begin
      logic [15:0] v;
      v = (j >= 8 && j < 12) ? 16'h8000 : (j >= 16) ? 16'h0000 : 16'h7FFF;
      send(v, v, (j % 8) == 7, 0);
    end
    chk("sat_count", 1, 32'(q1.size()), 32'd16);
    for (int j = 0; j < 16; j++)
      chk("sat_seq", 1, (j < q1.size()) ? 32'(q1[j]) : 32'hDEAD, 32'(sat_exp[j]));

    // Misaligned in_last at FILL cnt=2; error must stick until reset.
    do_reset();
    for (int j = 0; j < 16; j++) send(16'($urandom), 16'($urandom), j == 2, 20);
    chk("frame_err_sticky", 0, 32'(fe[0]), 32'd1);
    do_reset();

    // Reset in the middle of the BFLY half, then a fresh frame.
    for (int j = 0; j < 6; j++) send(16'($urandom), 16'($urandom), 1'b0, 0);
    do_reset();
    for (int j = 0; j < 24; j++) send(16'($urandom), 16'($urandom), (j % 8) == 7, 30);

    for (int k = 0; k < NI; k++) chk("out_count", k, 32'(n_out_dut[k]), 32'(n_out_model[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
